// File: rtl/lopd_normalize_pipe.sv
// rtl/lopd_normalize_pipe.sv - two-stage FP32 mantissa normalization behind the leading-one detector
//
// Purpose:
//   Takes an operand (sign, biased exponent, un-normalized mantissa) plus the
//   leading-one position and zero flag from the LOPD. It shifts the mantissa
//   left so the leading one sits at bit SIZE_DATA-1, and it lowers the exponent
//   by the same amount. Zero operands and exponent underflow are flushed to zero.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge) and asynchronous active-low reset
//   i_valid / o_ready   upstream handshake
//   i_sign, i_exp,
//   i_mant              operand fields
//   i_one_position      index of the most significant 1 in i_mant
//   i_zero_flag         i_mant is all zeros
//   o_valid / i_ready   downstream handshake
//   o_sign, o_exp,
//   o_mant              normalized result
//   o_zero              result flushed to zero
//   o_underflow         the flush was caused by exponent underflow
module lopd_normalize_pipe #(
    parameter int SIZE_DATA = 24,
    parameter int SIZE_LOPD = 5,
    parameter int SIZE_EXP  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_sign,
    input  logic [SIZE_EXP-1:0]  i_exp,
    input  logic [SIZE_DATA-1:0] i_mant,
    input  logic [SIZE_LOPD-1:0] i_one_position,
    input  logic                 i_zero_flag,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_sign,
    output logic [SIZE_EXP-1:0]  o_exp,
    output logic [SIZE_DATA-1:0] o_mant,
    output logic                 o_zero,
    output logic                 o_underflow
);

    localparam logic [SIZE_LOPD-1:0] MAX_POS = SIZE_LOPD'(SIZE_DATA - 1);

    // Stage A registers
    logic                 va_q, va_d;
    logic                 sign_a_q, sign_a_d;
    logic [SIZE_EXP-1:0]  exp_a_q, exp_a_d;
    logic [SIZE_DATA-1:0] mant_a_q, mant_a_d;
    logic                 zero_a_q, zero_a_d;
    logic [SIZE_LOPD-1:0] shift_a_q, shift_a_d;

    // Stage B (output) registers
    logic                 vb_q, vb_d;
    logic                 sign_b_q, sign_b_d;
    logic [SIZE_EXP-1:0]  exp_b_q, exp_b_d;
    logic [SIZE_DATA-1:0] mant_b_q, mant_b_d;
    logic                 zero_b_q, zero_b_d;
    logic                 uf_b_q, uf_b_d;

    logic                 adv_a, adv_b;
    logic [SIZE_LOPD-1:0] shift_in;
    logic [SIZE_EXP:0]    exp_ext, shift_ext;

    // Each stage advances when it is empty or the stage behind it moves, so a
    // full pipeline that is also draining keeps accepting one operand per cycle.
    always_comb begin
        adv_b = ~vb_q | i_ready;
        adv_a = ~va_q | adv_b;
    end

    assign o_ready = adv_a;

    // Stage A: capture the operand and turn the leading-one index into a
    // left-shift distance. An out-of-range index is treated as already normalized.
    always_comb begin
        shift_in  = (i_one_position > MAX_POS) ? '0 : (MAX_POS - i_one_position);

        va_d      = va_q;
        sign_a_d  = sign_a_q;
        exp_a_d   = exp_a_q;
        mant_a_d  = mant_a_q;
        zero_a_d  = zero_a_q;
        shift_a_d = shift_a_q;
        if (adv_a) begin
            va_d      = i_valid;
            sign_a_d  = i_sign;
            exp_a_d   = i_exp;
            mant_a_d  = i_mant;
            zero_a_d  = i_zero_flag;
            shift_a_d = shift_in;
        end
    end

    // Stage B: select the normalized, zero or underflow result. The exponent
    // compare uses one extra bit so the shift never aliases against the exponent.
    always_comb begin
        exp_ext   = {1'b0, exp_a_q};
        shift_ext = {{(SIZE_EXP + 1 - SIZE_LOPD){1'b0}}, shift_a_q};

        vb_d      = vb_q;
        sign_b_d  = sign_b_q;
        exp_b_d   = exp_b_q;
        mant_b_d  = mant_b_q;
        zero_b_d  = zero_b_q;
        uf_b_d    = uf_b_q;
        if (adv_b) begin
            vb_d = va_q;
            // Result fields only change when a real operand moves in, so the
            // outputs do not toggle across bubbles.
            if (va_q) begin
                sign_b_d = sign_a_q;
                if (zero_a_q) begin
                    exp_b_d  = '0;
                    mant_b_d = '0;
                    zero_b_d = 1'b1;
                    uf_b_d   = 1'b0;
                end else if (exp_ext <= shift_ext) begin
                    exp_b_d  = '0;
                    mant_b_d = '0;
                    zero_b_d = 1'b1;
                    uf_b_d   = 1'b1;
                end else begin
                    exp_b_d  = exp_a_q - shift_ext[SIZE_EXP-1:0];
                    mant_b_d = mant_a_q << shift_a_q;
                    zero_b_d = 1'b0;
                    uf_b_d   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            va_q      <= 1'b0;
            sign_a_q  <= 1'b0;
            exp_a_q   <= '0;
            mant_a_q  <= '0;
            zero_a_q  <= 1'b0;
            shift_a_q <= '0;
            vb_q      <= 1'b0;
            sign_b_q  <= 1'b0;
            exp_b_q   <= '0;
            mant_b_q  <= '0;
            zero_b_q  <= 1'b0;
            uf_b_q    <= 1'b0;
        end else begin
            va_q      <= va_d;
            sign_a_q  <= sign_a_d;
            exp_a_q   <= exp_a_d;
            mant_a_q  <= mant_a_d;
            zero_a_q  <= zero_a_d;
            shift_a_q <= shift_a_d;
            vb_q      <= vb_d;
            sign_b_q  <= sign_b_d;
            exp_b_q   <= exp_b_d;
            mant_b_q  <= mant_b_d;
            zero_b_q  <= zero_b_d;
            uf_b_q    <= uf_b_d;
        end
    end

    assign o_valid     = vb_q;
    assign o_sign      = sign_b_q;
    assign o_exp       = exp_b_q;
    assign o_mant      = mant_b_q;
    assign o_zero      = zero_b_q;
    assign o_underflow = uf_b_q;

endmodule

// File: tb/tb_lopd_normalize_pipe.sv
// tb/tb_lopd_normalize_pipe.sv - self-checking bench for lopd_normalize_pipe
module tb_lopd_normalize_pipe;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_sign = 1'b0;
    logic [7:0]  i_exp = '0;
    logic [23:0] i_mant = '0;
    logic [4:0]  i_one_position = '0;
    logic        i_zero_flag = 1'b0;
    logic        i_ready = 1'b0;
    logic        o_ready, o_valid, o_sign, o_zero, o_underflow;
    logic [7:0]  o_exp;
    logic [23:0] o_mant;

    lopd_normalize_pipe #(.SIZE_DATA(24), .SIZE_LOPD(5), .SIZE_EXP(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_sign(i_sign), .i_exp(i_exp), .i_mant(i_mant),
        .i_one_position(i_one_position), .i_zero_flag(i_zero_flag),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_sign(o_sign), .o_exp(o_exp), .o_mant(o_mant),
        .o_zero(o_zero), .o_underflow(o_underflow)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;
        logic        zero;
        logic        uf;
    } res_t;

    res_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_in = 0;
    int   n_out = 0;
    bit   rand_ready = 1'b0;

    function automatic res_t model(input logic s, input logic [7:0] e, input logic [23:0] m,
                                   input logic [4:0] pos, input logic zf);
        res_t r;
        int   sh;
        r      = '0;
        r.sign = s;
        sh     = (int'(pos) > 23) ? 0 : 23 - int'(pos);
        if (zf) begin
            r.zero = 1'b1;
        end else if (int'(e) <= sh) begin
            r.zero = 1'b1;
            r.uf   = 1'b1;
        end else begin
            r.mant = m << sh;
            r.exp  = 8'(int'(e) - sh);
        end
        return r;
    endfunction

    function automatic logic [4:0] lead_one(input logic [23:0] m);
        logic [4:0] p;
        p = '0;
        for (int i = 0; i < 24; i++) if (m[i]) p = 5'(i);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
            $error("check %s did not match", tag);
        end
    endtask

    // Scoreboard: expected results are pushed when an operand transfers in and
    // popped when a result transfers out. Sampled on the falling edge.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_valid && i_ready) begin
                n_out++;
                if (q.size() == 0) chk("unexpected_output", 64'd1, 64'd0);
                else chk("result", 64'({o_sign, o_exp, o_mant, o_zero, o_underflow}),
                         64'(q.pop_front()));
            end
            if (i_valid && o_ready) begin
                q.push_back(model(i_sign, i_exp, i_mant, i_one_position, i_zero_flag));
                n_in++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input logic s, input logic [7:0] e, input logic [23:0] m,
                        input logic [4:0] pos, input logic zf);
        logic acc;
        i_valid = 1'b1; i_sign = s; i_exp = e; i_mant = m;
        i_one_position = pos; i_zero_flag = zf;
        for (int k = 0; k < 200; k++) begin
            @(negedge i_clk);
            acc = o_ready;
            @(posedge i_clk);
            #1;
            if (acc) begin
                i_valid = 1'b0;
                return;
            end
            if (rand_ready) i_ready = 1'($urandom_range(0, 1));
        end
        chk("accept_timeout", 64'd0, 64'd1);
        i_valid = 1'b0;
    endtask

    task automatic send_op(input logic s, input logic [7:0] e, input logic [23:0] m);
        send(s, e, m, lead_one(m), m == 24'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
            if (rand_ready) i_ready = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] m;
        int          n0_in, n0_out;

        // Reset state
        #2 i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_outputs", 64'({o_sign, o_exp, o_mant, o_zero, o_underflow}), 64'd0);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        chk("rst_o_ready", 64'(o_ready), 64'd1);

        // Test 1: latency of two cycles, shift by 23
        send_op(1'b1, 8'd100, 24'h000001);
        chk("lat_not_yet_valid", 64'(o_valid), 64'd0);
        @(posedge i_clk);
        #1;
        chk("lat_o_valid", 64'(o_valid), 64'd1);
        chk("lat_o_mant", 64'(o_mant), 64'h800000);
        chk("lat_o_exp", 64'(o_exp), 64'd77);
        chk("lat_o_sign", 64'(o_sign), 64'd1);
        chk("lat_o_zero", 64'(o_zero), 64'd0);

        // Test 2/3: already normalized, exp lands on 1, underflow boundary,
        // illegal position, zero flag, exp equal to shift
        send_op(1'b0, 8'd5, 24'h800000);
        send_op(1'b0, 8'd14, 24'h000400);
        send_op(1'b1, 8'd13, 24'h000400);
        send(1'b0, 8'd10, 24'h400000, 5'd31, 1'b0);
        send(1'b0, 8'd120, 24'h000000, 5'd0, 1'b1);
        send_op(1'b1, 8'd23, 24'h000001);
        send_op(1'b0, 8'd255, 24'h0000FF);
        idle(4);
        chk("directed_drained", 64'(q.size()), 64'd0);

        // Test 4: backpressure, two operands buffered, third held upstream
        i_ready = 1'b0;
        send_op(1'b0, 8'd50, 24'h000F00);
        send_op(1'b1, 8'd60, 24'h00000A);
        chk("stall_o_ready_drop", 64'(o_ready), 64'd0);
        i_valid = 1'b1; i_sign = 1'b0; i_exp = 8'd70; i_mant = 24'h123456;
        i_one_position = lead_one(24'h123456); i_zero_flag = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("stall_o_valid", 64'(o_valid), 64'd1);
            chk("stall_o_mant", 64'(o_mant), 64'hF00000);
            chk("stall_o_exp", 64'(o_exp), 64'd38);
            chk("stall_o_ready", 64'(o_ready), 64'd0);
        end
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        @(negedge i_clk);
        chk("drain_1_valid", 64'(o_valid), 64'd1);
        chk("drain_ready_up", 64'(o_ready), 64'd1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("drain_2_valid", 64'(o_valid), 64'd1);
        @(negedge i_clk);
        chk("drain_3_valid", 64'(o_valid), 64'd1);
        @(posedge i_clk);
        #1;
        idle(3);
        chk("stall_drained", 64'(q.size()), 64'd0);

        // Test 5: asynchronous reset with both stages full
        i_ready = 1'b0;
        send_op(1'b1, 8'd90, 24'h00F0F0);
        send_op(1'b1, 8'd91, 24'h0F0F0F);
        chk("prereset_o_valid", 64'(o_valid), 64'd1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("async_rst_o_valid", 64'(o_valid), 64'd0);
        chk("async_rst_outputs", 64'({o_sign, o_exp, o_mant, o_zero, o_underflow}), 64'd0);
        q.delete();
        i_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        chk("post_rst_o_ready", 64'(o_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            chk("no_stale_result", 64'(o_valid), 64'd0);
        end
        @(posedge i_clk);
        #1;

        // Test 6: random operands with random valid/ready gaps
        n0_in  = n_in;
        n0_out = n_out;
        rand_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            idle($urandom_range(0, 2));
            case ($urandom_range(0, 3))
                0:       m = 24'd0;
                1:       m = 24'($urandom);
                default: m = 24'($urandom) >> $urandom_range(0, 23);
            endcase
            send_op(1'($urandom), 8'($urandom), m);
        end
        rand_ready = 1'b0;
        i_ready = 1'b1;
        idle(6);
        chk("rand_in_count", 64'(n_in - n0_in), 64'd100);
        chk("rand_out_count", 64'(n_out - n0_out), 64'd100);
        chk("rand_drained", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lopd_normalize_pipe.md
Name: lopd_normalize_pipe

Overview:
Normalization stage directly downstream of the 24-bit leading-one position detector in the FP32 datapath.
- Consumes the detector's leading-one position and zero flag together with the sign, exponent and mantissa of the same operand.
- Left-shifts the mantissa so the leading one lands at bit SIZE_DATA-1, and reduces the exponent by the shift amount.
- Flushes zero and underflow results to zero.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
SIZE_DATA, 24, mantissa width including hidden bit
SIZE_LOPD, 5, width of leading-one position field
SIZE_EXP, 8, biased exponent width

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  reset, asynchronous, active-low
i_valid  input  1  upstream operand valid
o_ready  output  1  block can accept an operand this cycle
i_sign  input  1  operand sign
i_exp  input  SIZE_EXP  biased exponent before normalization
i_mant  input  SIZE_DATA  un-normalized mantissa
i_one_position  input  SIZE_LOPD  index of the most significant 1 in i_mant (from the LOPD)
i_zero_flag  input  1  i_mant is all zeros (from the LOPD)
o_valid  output  1  normalized result valid
i_ready  input  1  downstream accepts the result
o_sign  output  1  result sign, passed through
o_exp  output  SIZE_EXP  normalized exponent
o_mant  output  SIZE_DATA  normalized mantissa
o_zero  output  1  result flushed to zero
o_underflow  output  1  flush to zero was caused by exponent underflow

Behaviour:
- Reset (i_rst_n low, asynchronous): both stage valids cleared and all output registers cleared, so o_valid=0, o_sign=0, o_exp=0, o_mant=0, o_zero=0, o_underflow=0. Immediately after reset, o_ready=1. Operands in flight are discarded.
- Handshake:
  - Input transfer when i_valid & o_ready.
  - Output transfer when o_valid & i_ready.
  - advB = ~vB | i_ready; advA = ~vA | advB; o_ready = advA (combinational from i_ready and the valids; no combinational path from i_valid).
- Stage A, registered when advA:
  - Captures sign, exp, mant, zero flag and valid.
  - Computes shift = (SIZE_DATA-1) - i_one_position, SIZE_LOPD bits.
  - If i_one_position > SIZE_DATA-1 (illegal), shift = 0.
- Stage B, registered when advB; loads vB <= vA. Result is selected by:
  - zero flag set: o_mant=0, o_exp=0, o_zero=1, o_underflow=0.
  - else if exp <= shift (compared in SIZE_EXP+1 bits): o_mant=0, o_exp=0, o_zero=1, o_underflow=1.
  - else: o_mant = mant << shift, o_exp = exp - shift, o_zero=0, o_underflow=0.
  - o_sign is always passed through unchanged.
- Latency: 2 cycles from input transfer to o_valid with no backpressure. Throughput: 1 operand per cycle.
- Stall: while o_valid & ~i_ready, every output holds stable. Stage A fills, then o_ready drops. Exactly 2 operands are buffered and none is lost or duplicated.
- Simultaneous output transfer and full pipeline: both stages advance in the same cycle, so o_ready stays 1.
- Ordering: results leave in strict input order.

Test Plan:
1. i_mant=0x000001, i_one_position=0, i_exp=100, i_sign=1, i_ready=1 -> 2 cycles later o_valid=1, o_mant=0x800000, o_exp=77, o_sign=1, o_zero=0.
2. i_mant=0x800000, i_one_position=23, i_exp=5 -> o_mant=0x800000, o_exp=5 unchanged. i_mant=0x000400, i_one_position=10, i_exp=14 (shift 13) -> o_mant=0x800000, o_exp=1. Same input with i_exp=13 -> o_zero=1, o_underflow=1, o_mant=0, o_exp=0.
3. i_zero_flag=1, i_mant=0, i_exp=120 -> o_zero=1, o_underflow=0, o_exp=0, o_mant=0.
4. Backpressure: i_ready=0, send operands A, B, C back to back -> A and B are accepted; o_ready=0 from the cycle after B is accepted; C is held upstream. o_valid=1 shows A stable while i_ready=0. Raise i_ready -> A, B, C delivered in order on consecutive cycles.
5. Reset mid-stream: assert i_rst_n=0 with both stages valid -> o_valid=0 and all outputs 0 immediately, without waiting for a clock edge. After release, o_ready=1 and no stale result appears.
6. Random: 100 operands with random i_valid/i_ready gaps; the model is a leading-one search plus the rules above -> every output matches the model, and the output count equals the input count.
